// File: rtl/sha256_compress_ctrl.sv
// SHA-256 block compression sequencer: streams 16 message words, runs ROUNDS single-cycle
// rounds with a sliding 16-word schedule window, then folds the working registers into the chaining hash.
module sha256_compress_ctrl #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         first_block,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_word,
  output logic         busy,
  output logic [5:0]   round_idx,
  output logic         digest_valid,
  output logic [255:0] digest
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL} state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t        state_q;
  logic [31:0]   wk_q   [8];
  logic [31:0]   hash_q [8];
  logic [31:0]   w_q    [16];
  logic [3:0]    cnt_q;
  logic [5:0]    t_q;
  logic          msg_ready_q;
  logic          busy_q;
  logic          digest_valid_q;
  logic [255:0]  digest_q;

  logic [31:0]   big_s0, big_s1, ch, maj;
  logic [31:0]   t1_d, t2_d, w_new_d;
  logic [31:0]   hsum_d [8];

  // w_q[0] always holds W_t; the value appended is W_{t+16}.
  always_comb begin
    big_s1  = rotr(wk_q[4], 6) ^ rotr(wk_q[4], 11) ^ rotr(wk_q[4], 25);
    ch      = (wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]);
    t1_d    = wk_q[7] + big_s1 + ch + K_ROM[t_q] + w_q[0];
    big_s0  = rotr(wk_q[0], 2) ^ rotr(wk_q[0], 13) ^ rotr(wk_q[0], 22);
    maj     = (wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]);
    t2_d    = big_s0 + maj;
    w_new_d = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
            + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    for (int i = 0; i < 8; i++) begin
      hsum_d[i] = hash_q[i] + wk_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      t_q            <= '0;
      msg_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      digest_valid_q <= 1'b0;
      digest_q       <= '0;
      for (int i = 0; i < 8; i++) begin
        wk_q[i]   <= '0;
        hash_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      digest_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            busy_q      <= 1'b1;
            msg_ready_q <= 1'b1;
            cnt_q       <= '0;
            t_q         <= '0;
            for (int i = 0; i < 8; i++) begin
              hash_q[i] <= first_block ? IV[i] : hash_q[i];
              wk_q[i]   <= first_block ? IV[i] : hash_q[i];
            end
          end
        end
        S_LOAD: begin
          if (msg_valid) begin
            w_q[cnt_q] <= msg_word;
            cnt_q      <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              msg_ready_q <= 1'b0;
              state_q     <= S_ROUND;
            end
          end
        end
        S_ROUND: begin
          wk_q[0] <= t1_d + t2_d;
          wk_q[1] <= wk_q[0];
          wk_q[2] <= wk_q[1];
          wk_q[3] <= wk_q[2];
          wk_q[4] <= wk_q[3] + t1_d;
          wk_q[5] <= wk_q[4];
          wk_q[6] <= wk_q[5];
          wk_q[7] <= wk_q[6];
          for (int i = 0; i < 15; i++) begin
            w_q[i] <= w_q[i + 1];
          end
          w_q[15] <= w_new_d;
          if (t_q == LAST_T) begin
            t_q     <= '0;
            state_q <= S_FINAL;
          end else begin
            t_q <= t_q + 6'd1;
          end
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) begin
            hash_q[i] <= hsum_d[i];
          end
          digest_q       <= {hsum_d[0], hsum_d[1], hsum_d[2], hsum_d[3],
                             hsum_d[4], hsum_d[5], hsum_d[6], hsum_d[7]};
          digest_valid_q <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign msg_ready    = msg_ready_q;
  assign busy         = busy_q;
  assign round_idx    = t_q;
  assign digest_valid = digest_valid_q;
  assign digest       = digest_q;

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Bench for sha256_compress_ctrl: known vectors, protocol corners, random blocks against a reference model.
module tb_sha256_compress_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         first_block = 1'b0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [31:0]  msg_word = '0;
  logic         busy;
  logic [5:0]   round_idx;
  logic         digest_valid;
  logic [255:0] digest;

  sha256_compress_ctrl #(.ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_block(first_block),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_word(msg_word),
    .busy(busy), .round_idx(round_idx), .digest_valid(digest_valid), .digest(digest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] IV_P =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct packed {
    logic         fb;
    logic [511:0] blk;
    logic         chk;
    logic [255:0] exp;
  } vec_t;

  vec_t tbl [4];

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4 compression over a full 64-word schedule.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  hh [8];
    logic [31:0]  t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) begin
      hh[i] = hin[255 - 32*i -: 32];
      v[i]  = hh[i];
    end
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    res = '0;
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hh[i] + v[i];
    return res;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_msg_ready"}, 256'(msg_ready), 256'd0);
    check({tag, "_busy"}, 256'(busy), 256'd0);
    check({tag, "_digest_valid"}, 256'(digest_valid), 256'd0);
    check({tag, "_round_idx"}, 256'(round_idx), 256'd0);
    check({tag, "_digest"}, digest, 256'd0);
  endtask

  // mode 0: plain; 1: stray start at round 30; 2: reset asserted at round 40.
  task automatic run_block(input logic fb, input logic [511:0] blk, input int gap_max, input int mode,
                           output logic [255:0] dg, output int lat, output int hs,
                           output int perr, output bit got);
    int idx, gap, r;
    bit hsn;
    logic [255:0] prev;
    idx = 0; gap = 0; r = 0;
    got = 0; lat = 0; hs = 0; perr = 0; dg = '0;
    prev = digest;
    @(negedge clk);
    if (busy) perr++;
    start = 1'b1;
    first_block = fb;
    @(posedge clk);
    lat = 1;
    #1;
    start = 1'b0;
    first_block = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (digest_valid) begin
        dg = digest;
        got = 1;
        break;
      end
      if (!busy) perr++;
      if (digest !== prev) perr++;
      if (idx < 16) begin
        if (!msg_ready || round_idx != 6'd0) perr++;
      end else begin
        if (msg_ready) perr++;
        if (round_idx != ((r < 64) ? 6'(r) : 6'd0)) perr++;
      end
      if (mode == 2 && idx == 16 && r == 40) begin
        rst_n = 1'b0;
        msg_valid = 1'b0;
        break;
      end
      start = (mode == 1 && idx == 16 && r == 30);
      if (idx < 16) begin
        if (gap > 0) begin
          msg_valid = 1'b0;
          msg_word = $urandom;
          gap--;
        end else begin
          msg_valid = 1'b1;
          msg_word = blk[511 - 32*idx -: 32];
        end
      end else begin
        msg_valid = 1'($urandom_range(0, 1));
        msg_word = $urandom;
      end
      hsn = msg_valid && msg_ready;
      @(posedge clk);
      lat++;
      if (idx == 16) r++;
      if (hsn) begin
        hs++;
        if (idx < 16) idx++;
        gap = $urandom_range(0, gap_max);
      end
      #1;
    end
    msg_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic after_block(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_pulse_end"}, 256'(digest_valid), 256'd0);
    check({tag, "_busy_end"}, 256'(busy), 256'd0);
  endtask

  logic [255:0] model_h;
  logic [255:0] exp_m;
  logic [255:0] dg;
  int lat, hs, perr;
  bit got;
  logic fb;
  logic [511:0] blk;

  initial begin
    tbl[0].fb = 1'b1; tbl[0].blk = ABC_BLK; tbl[0].chk = 1'b1; tbl[0].exp = ABC_DG;
    tbl[1].fb = 1'b1; tbl[1].blk = {32'h80000000, 480'h0}; tbl[1].chk = 1'b1;
    tbl[1].exp = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    tbl[2].fb = 1'b1; tbl[2].chk = 1'b0; tbl[2].exp = '0;
    tbl[2].blk = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                  32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                  32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    tbl[3].fb = 1'b0; tbl[3].blk = {480'h0, 32'h000001c0}; tbl[3].chk = 1'b1;
    tbl[3].exp = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    model_h = '0;

    for (int i = 0; i < 4; i++) begin
      exp_m = compress(tbl[i].fb ? IV_P : model_h, tbl[i].blk);
      model_h = exp_m;
      run_block(tbl[i].fb, tbl[i].blk, 0, 0, dg, lat, hs, perr, got);
      check($sformatf("vec%0d_got", i), 256'(got), 256'd1);
      check($sformatf("vec%0d_model", i), dg, exp_m);
      if (tbl[i].chk) check($sformatf("vec%0d_known", i), dg, tbl[i].exp);
      check($sformatf("vec%0d_latency", i), 256'(lat), 256'd82);
      check($sformatf("vec%0d_handshakes", i), 256'(hs), 256'd16);
      check($sformatf("vec%0d_protocol", i), 256'(perr), 256'd0);
      after_block($sformatf("vec%0d", i));
    end

    run_block(1'b1, ABC_BLK, 5, 0, dg, lat, hs, perr, got);
    model_h = ABC_DG;
    check("gaps_digest", dg, ABC_DG);
    check("gaps_handshakes", 256'(hs), 256'd16);
    check("gaps_protocol", 256'(perr), 256'd0);
    after_block("gaps");

    run_block(1'b1, ABC_BLK, 0, 1, dg, lat, hs, perr, got);
    check("stray_start_digest", dg, ABC_DG);
    check("stray_start_latency", 256'(lat), 256'd82);
    check("stray_start_protocol", 256'(perr), 256'd0);
    after_block("stray_start");

    for (int n = 0; n < 8; n++) begin
      fb = 1'($urandom_range(0, 2) == 0);
      for (int k = 0; k < 16; k++) blk[511 - 32*k -: 32] = $urandom;
      exp_m = compress(fb ? IV_P : model_h, blk);
      model_h = exp_m;
      run_block(fb, blk, 2, 0, dg, lat, hs, perr, got);
      check($sformatf("rand%0d_digest", n), dg, exp_m);
      check($sformatf("rand%0d_protocol", n), 256'(perr + hs - 16), 256'd0);
      after_block($sformatf("rand%0d", n));
    end

    run_block(1'b1, ABC_BLK, 0, 2, dg, lat, hs, perr, got);
    #1;
    check("abort_no_digest", 256'(got), 256'd0);
    chk_reset_outs("abort");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_hold_valid", 256'(digest_valid), 256'd0);
    end
    rst_n = 1'b1;
    model_h = '0;
    run_block(1'b1, ABC_BLK, 0, 0, dg, lat, hs, perr, got);
    check("post_abort_digest", dg, ABC_DG);
    check("post_abort_latency", 256'(lat), 256'd82);
    check("post_abort_protocol", 256'(perr), 256'd0);
    after_block("post_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
